// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin arbiter sharing one APB master port; APB_ARB_TIMEOUT_EN adds an ACCESS wait limit
module apb_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic                 PSEL1,
    output logic                 PSEL2,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [AW-1:0]        PADDR,
    output logic [DW-1:0]        PWDATA,
    input  logic [DW-1:0]        PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_t;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   owner;
    logic [GW-1:0]   gsel;
    logic [GW:0]     scan;
    logic            found;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic            g_write;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   tcnt;
`endif

    // Scan requesters starting at ptr, wrapping modulo NREQ; first set bit wins.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (GW+1)'(k);
            if (scan >= (GW+1)'(NREQ))
                scan = scan - (GW+1)'(NREQ);
            if (!found && req_valid[scan[GW-1:0]]) begin
                found = 1'b1;
                gsel  = scan[GW-1:0];
            end
        end
    end

    assign g_addr  = req_addr[gsel*AW +: AW];
    assign g_wdata = req_wdata[gsel*DW +: DW];
    assign g_write = req_write[gsel];

    // Gated by reset so the accept strobe stays low while the block is held in reset.
    assign req_ready = (state == IDLE && found && PRESETn) ? (NREQ'(1) << gsel) : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= gsel;
                        PWRITE <= g_write;
                        PADDR  <= g_addr;
                        PWDATA <= g_write ? g_wdata : '0;
                        PSEL1  <= ~g_addr[AW-1];
                        PSEL2  <= g_addr[AW-1];
                        ptr    <= (gsel == GW'(NREQ - 1)) ? '0 : gsel + 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        PSEL1     <= 1'b0;
                        PSEL2     <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (tcnt == CW'(TIMEOUT - 1)) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        PSEL1     <= 1'b0;
                        PSEL2     <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter and APB transfer sequencer that lets several local requesters share the single APB master port driving the two APB slaves. Each requester posts one read or write command. The arbiter grants one command at a time and runs the full IDLE→SETUP→ACCESS APB sequence for it. It then returns read data and error status to the requester that issued it. It sits between the requester-side logic and the APB slaves (PSEL1/PSEL2, selected by PADDR[8]).

## Interface
- NREQ, 4 — number of requesters (2..8)
- AW, 9 — address width; bit AW-1 selects the slave
- DW, 8 — data width
- TIMEOUT, 15 — ACCESS-phase wait limit in cycles (used only with APB_ARB_TIMEOUT_EN)

- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  command pending, one bit per requester
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  per-requester address; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  per-requester write data; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_rdata  out  DW  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- PSEL1, PSEL2  out  1 each  slave selects
- PENABLE, PWRITE  out  1 each  APB controls
- PADDR  out  AW  APB address
- PWDATA  out  DW  APB write data
- PRDATA  in  DW  APB read data
- PREADY, PSLVERR  in  1 each  APB slave response

## Operation
- States: IDLE, SETUP, ACCESS. One-hot encoding.
- IDLE:
  - If any req_valid is high, grant requester g, the first set bit searched from pointer ptr upward with modular wrap.
  - req_ready[g] = 1 combinationally in that cycle.
  - At the edge, capture req_write[g], req_addr[g], req_wdata[g] and g into internal registers, then go to SETUP.
  - Set ptr to (g+1) mod NREQ.
- SETUP:
  - PSEL1 = !PADDR[AW-1], PSEL2 = PADDR[AW-1].
  - PENABLE = 0. PADDR, PWRITE and PWDATA come from the captured registers; PWDATA = 0 for reads.
  - Always go to ACCESS next cycle.
- ACCESS:
  - PSEL held and PENABLE = 1.
  - If PREADY = 0, stay in ACCESS.
  - If PREADY = 1:
    - Register PRDATA into rsp_rdata (reads only; writes give 0).
    - Register PSLVERR into rsp_err.
    - Pulse rsp_valid[g] for exactly one cycle after the edge.
    - Go to IDLE.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS.
- req_valid may drop without a grant; the arbiter does not need the command to be held after req_ready.
- Arbitration is never preemptive. A new grant happens only in IDLE.
- With one requester active continuously, it is served every 3 cycles.

## Timing
- Reset (asynchronous assert, synchronous release): every output is 0; state = IDLE, ptr = 0.
- Accept to SETUP: 1 cycle. Minimum transfer is 3 cycles (IDLE accept, SETUP, ACCESS with PREADY = 1).
- rsp_valid occurs in the cycle after PREADY is sampled high. That cycle is also the next IDLE, so req_ready may assert in the same cycle for a different requester or the same one.
- Simultaneous requests: the lowest index at or above ptr wins. After a grant to NREQ-1, ptr wraps to 0.
- Reset mid-transfer: the transfer is abandoned and no rsp_valid is issued. PSEL and PENABLE drop immediately.
- PSLVERR is sampled only when PREADY = 1 in ACCESS and is ignored at all other times.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to ACCESS and increments each cycle while PREADY = 0.
  - If PREADY is still low when the counter reaches TIMEOUT, the arbiter ends the transfer: IDLE next, rsp_valid[g] pulses with rsp_err = 1 and rsp_rdata = 0.
- APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits for PREADY indefinitely.

## Test plan
- Single write: req_valid = 4'b0001, addr 0x012, wdata 0xA5 → req_ready[0] pulse; SETUP with PSEL1 = 1, PENABLE = 0, PWRITE = 1, PADDR = 0x012; ACCESS with PREADY = 1 → rsp_valid = 4'b0001, rsp_err = 0.
- Read from slave 2: requester 2 reads 0x1F0, slave returns PRDATA = 0x3C after 2 wait cycles → PSEL2 = 1; PENABLE high for 3 cycles; rsp_valid = 4'b0100, rsp_rdata = 0x3C.
- Round-robin: all four req_valid held high, zero-wait slave → grant order 0, 1, 2, 3, 0; each grant 3 cycles apart.
- Slave error: PSLVERR = 1 together with PREADY = 1 on a write → rsp_err = 1 for the owning requester; the next grant proceeds normally.
- Reset mid-ACCESS: PRESETn low while PREADY = 0 → all outputs 0 immediately; no rsp_valid; after release, ptr = 0 and requester 0 wins a 4'b1111 request.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT = 15): PREADY held 0 → after 15 ACCESS cycles the state returns to IDLE; rsp_valid pulses with rsp_err = 1 and rsp_rdata = 0x00.
